program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 116 +++++++++++
 tb/tb_program_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter with a return-address stack for call/ret.
// Define PC_TRAP_EN to vector to TRAP_ADDR and pulse trap on stack overflow/underflow.
module program_counter #(
  parameter int unsigned            BUS_WIDTH   = 8,
  parameter int unsigned            STACK_DEPTH = 4,
  parameter logic [BUS_WIDTH-1:0]   RESET_ADDR  = '0,
  parameter logic [BUS_WIDTH-1:0]   TRAP_ADDR   = '1,
  localparam int unsigned           DepthW      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] in,
  input  logic                 load,
  input  logic                 inc,
  input  logic                 call,
  input  logic                 ret,
  output logic [BUS_WIDTH-1:0] out,
  output logic [DepthW-1:0]    depth,
  output logic                 stack_full,
  output logic                 stack_empty,
  output logic                 fault,
  output logic                 trap
);

  localparam logic [DepthW-1:0] FullDepth = DepthW'(STACK_DEPTH);

  logic [BUS_WIDTH-1:0] out_q, out_d;
  logic [DepthW-1:0]    depth_q, depth_d;
  logic                 fault_q, fault_d;
  logic [BUS_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [BUS_WIDTH-1:0] next_addr, top;
  logic                 push, fault_ev;

  assign next_addr   = out_q + BUS_WIDTH'(1);
  assign stack_full  = (depth_q == FullDepth);
  assign stack_empty = (depth_q == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DepthW'(i + 1)) top = stack_q[i];
    end
  end

  // Fixed priority: ret > call > load > inc > hold.
  always_comb begin
    out_d    = out_q;
    depth_d  = depth_q;
    fault_d  = fault_q;
    push     = 1'b0;
    fault_ev = 1'b0;
    if (ret) begin
      if (stack_empty) begin
        fault_ev = 1'b1;
      end else begin
        out_d   = top;
        depth_d = depth_q - DepthW'(1);
      end
    end else if (call) begin
      if (stack_full) begin
        fault_ev = 1'b1;
      end else begin
        push    = 1'b1;
        out_d   = in;
        depth_d = depth_q + DepthW'(1);
      end
    end else if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d = next_addr;
    end
    if (fault_ev) begin
      fault_d = 1'b1;
`ifdef PC_TRAP_EN
      out_d = TRAP_ADDR;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_q   <= RESET_ADDR;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // Entries carry no reset; they are only read after being written.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (depth_q == DepthW'(i)) stack_q[i] <= next_addr;
      end
    end
  end

`ifdef PC_TRAP_EN
  logic trap_q;
  always_ff @(posedge clock) begin
    if (!reset_n) trap_q <= 1'b0;
    else          trap_q <= fault_ev;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign out   = out_q;
  assign depth = depth_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (default parameters).
module tb_program_counter;

`ifdef PC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n, load, inc, call, ret;
  logic [7:0] in;
  logic [7:0] out;
  logic [2:0] depth;
  logic       stack_full, stack_empty, fault, trap;
  int         total = 0;
  int         bad = 0;

  program_counter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in         (in),
    .load       (load),
    .inc        (inc),
    .call       (call),
    .ret        (ret),
    .out        (out),
    .depth      (depth),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .fault      (fault),
    .trap       (trap)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    {load, inc, call, ret} = 4'b0000;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_out;
    do_reset();
    total++;
    if (out !== 8'h00 || depth !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0 ||
        fault !== 1'b0 || trap !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%h depth=%0d empty=%b full=%b fault=%b trap=%b", out, depth,
               stack_empty, stack_full, fault, trap);
    end
    inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_out = 8'(i);
      total++;
      if (out !== exp_out || depth !== 3'd0 || stack_empty !== 1'b1) begin
        bad++;
        $display("FAIL inc_%0d: out=%h depth=%0d empty=%b want out=%h depth=0 empty=1", i, out,
                 depth, stack_empty, exp_out);
      end
    end
    idle();
    step();
    total++;
    if (out !== 8'h03) begin
      bad++;
      $display("FAIL hold: out=%h want 03", out);
    end
  endtask

  task automatic test_jump_wrap();
    logic [7:0] exp_seq [3];
    exp_seq = '{8'hFE, 8'hFF, 8'h00};
    load = 1'b1;
    in   = 8'hFE;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out !== exp_seq[i]) begin
        bad++;
        $display("FAIL jump_wrap_%0d: out=%h want %h", i, out, exp_seq[i]);
      end
      inc = 1'b1;
      if (i < 2) step();
    end
    idle();
  endtask

  task automatic test_nested();
    logic [7:0] exp_out [4];
    logic [2:0] exp_dep [4];
    exp_out = '{8'h40, 8'h80, 8'h41, 8'h11};
    exp_dep = '{3'd1, 3'd2, 3'd1, 3'd0};
    do_reset();
    load = 1'b1;
    in   = 8'h10;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      call = (i < 2);
      ret  = (i >= 2);
      in   = (i == 0) ? 8'h40 : 8'h80;
      step();
      total++;
      if (out !== exp_out[i] || depth !== exp_dep[i]) begin
        bad++;
        $display("FAIL nested_%0d: out=%h depth=%0d want out=%h depth=%0d", i, out, depth,
                 exp_out[i], exp_dep[i]);
      end
    end
    idle();
    total++;
    if (stack_empty !== 1'b1 || fault !== 1'b0) begin
      bad++;
      $display("FAIL nested_end: empty=%b fault=%b want 1 0", stack_empty, fault);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_out;
    logic [7:0] targets [5];
    targets = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    // Starts at out=11, depth 0: pushes 12, 21, 31, 41.
    for (int i = 0; i < 5; i++) begin
      call = 1'b1;
      in   = targets[i];
      step();
      if (i < 4) begin
        total++;
        if (depth !== 3'(i + 1) || out !== targets[i] || fault !== 1'b0) begin
          bad++;
          $display("FAIL ovf_call_%0d: depth=%0d out=%h fault=%b want %0d %h 0", i, depth, out,
                   fault, i + 1, targets[i]);
        end
      end
    end
    idle();
    exp_out = TrapEn ? 8'hFF : 8'h50;
    total++;
    if (depth !== 3'd4 || stack_full !== 1'b1 || fault !== 1'b1 || out !== exp_out ||
        trap !== TrapEn) begin
      bad++;
      $display("FAIL overflow: depth=%0d full=%b fault=%b out=%h trap=%b want 4 1 1 %h %b", depth,
               stack_full, fault, out, trap, exp_out, TrapEn);
    end
    step();
    total++;
    if (trap !== 1'b0 || out !== exp_out) begin
      bad++;
      $display("FAIL trap_pulse: trap=%b out=%h want 0 %h", trap, out, exp_out);
    end
    // Overflow left the stack intact; fault stays set while rets run normally.
    ret = 1'b1;
    step();
    total++;
    if (out !== 8'h41 || depth !== 3'd3 || fault !== 1'b1) begin
      bad++;
      $display("FAIL ovf_ret: out=%h depth=%0d fault=%b want 41 3 1", out, depth, fault);
    end
    step();
    total++;
    if (out !== 8'h31 || depth !== 3'd2) begin
      bad++;
      $display("FAIL ovf_ret2: out=%h depth=%0d want 31 2", out, depth);
    end
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    load = 1'b1;
    in   = 8'h20;
    step();
    load = 1'b0;
    call = 1'b1;
    in   = 8'h50;
    step();
    {ret, call, load, inc} = 4'b1111;
    in = 8'h77;
    step();
    total++;
    if (out !== 8'h21 || depth !== 3'd0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL prio_ret: out=%h depth=%0d fault=%b want 21 0 0", out, depth, fault);
    end
    {ret, call, load, inc} = 4'b0111;
    in = 8'h33;
    step();
    total++;
    if (out !== 8'h33 || depth !== 3'd1) begin
      bad++;
      $display("FAIL prio_call: out=%h depth=%0d want 33 1", out, depth);
    end
    {ret, call, load, inc} = 4'b0011;
    in = 8'h05;
    step();
    total++;
    if (out !== 8'h05 || depth !== 3'd1) begin
      bad++;
      $display("FAIL prio_load: out=%h depth=%0d want 05 1", out, depth);
    end
    idle();
  endtask

  task automatic test_underflow_reset();
    logic [7:0] exp_out;
    do_reset();
    load = 1'b1;
    in   = 8'h30;
    step();
    load = 1'b0;
    ret  = 1'b1;
    step();
    idle();
    exp_out = TrapEn ? 8'hFF : 8'h30;
    total++;
    if (fault !== 1'b1 || depth !== 3'd0 || out !== exp_out || trap !== TrapEn) begin
      bad++;
      $display("FAIL underflow: fault=%b depth=%0d out=%h trap=%b want 1 0 %h %b", fault, depth,
               out, trap, exp_out, TrapEn);
    end
    reset_n = 1'b0;
    call    = 1'b1;
    in      = 8'h55;
    step();
    total++;
    if (out !== 8'h00 || fault !== 1'b0 || depth !== 3'd0 || trap !== 1'b0) begin
      bad++;
      $display("FAIL reset_call: out=%h fault=%b depth=%0d trap=%b want 00 0 0 0", out, fault,
               depth, trap);
    end
    reset_n = 1'b1;
    idle();
    step();
    total++;
    if (out !== 8'h00 || depth !== 3'd0 || stack_empty !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: out=%h depth=%0d empty=%b want 00 0 1", out, depth, stack_empty);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in      = 8'h00;
    idle();
    test_reset();
    test_jump_wrap();
    test_nested();
    test_overflow();
    test_priority();
    test_underflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
